// File: rtl/vga_scanout.sv
// Programmable VGA timing generator with framebuffer scan-out.
// Compensates the framebuffer read latency so sync, DE and pixel leave aligned.
`timescale 1ns/1ps
module vga_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 56,
    parameter int unsigned H_SYNC      = 56,
    parameter int unsigned H_BP        = 80,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 1,
    parameter int unsigned V_SYNC      = 3,
    parameter int unsigned V_BP        = 25,
    parameter int unsigned HSYNC_POL   = 0,
    parameter int unsigned VSYNC_POL   = 0,
    parameter int unsigned SCALE_SHIFT = 3,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned MEM_LAT     = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              en,
    input  logic [PIX_W-1:0]  border,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    input  logic [PIX_W-1:0]  fb_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [PIX_W-1:0]  pixel,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0]    H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0]    H_ACT  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0]    HS_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0]    HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0]    V_LAST = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0]    V_ACT  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0]    VS_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0]    VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0]    V_MASK = VCW'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
    localparam logic              HS_ON  = 1'(HSYNC_POL);
    localparam logic              VS_ON  = 1'(VSYNC_POL);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic en;
        logic org;
    } flags_t;

    logic [HCW-1:0]    hcnt_q, hcnt_d;
    logic [VCW-1:0]    vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_rd_q, fb_rd_d;
    logic              en_frame_q, en_frame_d;
    logic              first_q;
    logic              origin_d;
    logic              act_d;
    flags_t            s0_c;
    flags_t            tap_c;
    flags_t            dly_q [MEM_LAT];
    logic              de_q, de_d;
    logic [PIX_W-1:0]  pixel_q, pixel_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              fs_q, fs_d;

    // Next raster position, row base and look-ahead fetch for that position.
    always_comb begin
        hcnt_d     = hcnt_q + HCW'(1);
        vcnt_d     = vcnt_q;
        row_d      = row_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCW'(1);
            if (vcnt_d == '0) begin
                row_d = '0;
            end else if ((vcnt_d < V_ACT) && ((vcnt_d & V_MASK) == '0)) begin
                row_d = row_q + FB_W_A;
            end
        end
        origin_d   = (hcnt_d == '0) && (vcnt_d == '0);
        en_frame_d = (origin_d || first_q) ? en : en_frame_q;
        act_d      = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        fb_rd_d    = act_d && en_frame_d;
        fb_addr_d  = fb_rd_d ? (row_d + ADDR_W'(hcnt_d >> SCALE_SHIFT)) : fb_addr_q;
    end

    // Stage-0 timing flags and the final output stage fed by the delay tap.
    always_comb begin
        s0_c.act = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        s0_c.hs  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
        s0_c.vs  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
        s0_c.en  = en_frame_q;
        s0_c.org = (hcnt_q == '0) && (vcnt_q == '0);
        tap_c    = dly_q[MEM_LAT-1];
        de_d     = tap_c.act;
        pixel_d  = '0;
        if (tap_c.act) begin
            pixel_d = tap_c.en ? fb_data : border;
        end
        hsync_d  = tap_c.hs ? HS_ON : ~HS_ON;
        vsync_d  = tap_c.vs ? VS_ON : ~VS_ON;
        fs_d     = tap_c.org;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            row_q      <= '0;
            fb_addr_q  <= '0;
            fb_rd_q    <= 1'b0;
            en_frame_q <= 1'b0;
            first_q    <= 1'b1;
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                dly_q[i] <= '0;
            end
            de_q       <= 1'b0;
            pixel_q    <= '0;
            hsync_q    <= ~HS_ON;
            vsync_q    <= ~VS_ON;
            fs_q       <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            row_q      <= row_d;
            fb_addr_q  <= fb_addr_d;
            fb_rd_q    <= fb_rd_d;
            en_frame_q <= en_frame_d;
            first_q    <= 1'b0;
            dly_q[0]   <= s0_c;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            de_q       <= de_d;
            pixel_q    <= pixel_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            fs_q       <= fs_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_rd       = fb_rd_q;
    assign de          = de_q;
    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule
